// File: rtl/char_sel_pkg.sv
// Shared definitions for the enigma character selector: default width,
// channel-index width helper and selection-mode encoding.
package char_sel_pkg;

   localparam int DEF_DW = 8;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   // Channel-index width; a single channel pair still needs one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/char_rr_pick.sv
// Combinational channel picker: fixed priority from index 0, or
// round-robin search upward from a start index with wrap.
module char_rr_pick
   import char_sel_pkg::*;
#(
   parameter int NCH = 4,
   parameter int IW  = idx_w(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  start,
   input  mode_e          mode,
   output logic [IW-1:0]  grant,
   output logic           any_req
);

   always_comb begin
      int unsigned j;
      grant   = '0;
      any_req = 1'b0;
      j       = 0;
      for (int unsigned k = 0; k < NCH; k++) begin
         j = (mode == MODE_RR) ? int'(start) + k : k;
         if (j >= NCH) j = j - NCH;
         if (!any_req && req[j[IW-1:0]]) begin
            grant   = j[IW-1:0];
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/char_select_arb.sv
// N-channel registered character selector with valid/ready handshake and
// transfer counter. Define CHAR_SELECT_SKID_EN for the one-entry skid build.
module char_select_arb
   import char_sel_pkg::*;
#(
   parameter int NCH = 4,
   parameter int DW  = DEF_DW,
   parameter int CW  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rr_mode,
   input  logic [NCH-1:0]          in_valid,
   input  logic [NCH*DW-1:0]       in_data,
   output logic [NCH-1:0]          in_ready,
   output logic                    out_valid,
   output logic [DW-1:0]           out_data,
   output logic [idx_w(NCH)-1:0]   out_ch,
   input  logic                    out_ready,
   output logic [CW-1:0]           xfer_count
);

   localparam int IW = idx_w(NCH);

   logic [IW-1:0] last_grant;
   logic [IW-1:0] start;
   logic [IW-1:0] grant;
   logic          any_req;
   logic          slot_free;
   logic          accept_ok;
   logic          in_xfer;
   logic          out_xfer;
   logic [DW-1:0] sel_data;

`ifdef CHAR_SELECT_SKID_EN
   logic          skid_valid;
   logic [DW-1:0] skid_data;
   logic [IW-1:0] skid_ch;
`endif

   assign start = (last_grant == IW'(NCH - 1)) ? '0 : last_grant + 1'b1;

   char_rr_pick #(
      .NCH (NCH),
      .IW  (IW)
   ) u_pick (
      .req     (in_valid),
      .start   (start),
      .mode    (mode_e'(rr_mode)),
      .grant   (grant),
      .any_req (any_req)
   );

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (grant == i[IW-1:0]) sel_data = in_data[i*DW +: DW];
      end
   end

   assign slot_free = !out_valid || out_ready;
   assign out_xfer  = out_valid && out_ready;

`ifdef CHAR_SELECT_SKID_EN
   // Acceptance looks only at local skid state, breaking the out_ready path.
   assign accept_ok = !skid_valid;
`else
   assign accept_ok = slot_free;
`endif

   assign in_xfer = any_req && accept_ok && !rst;

   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         in_ready[i] = in_xfer && (grant == i[IW-1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ch     <= '0;
         xfer_count <= '0;
         last_grant <= IW'(NCH - 1);
`ifdef CHAR_SELECT_SKID_EN
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_ch    <= '0;
`endif
      end else begin
         if (out_xfer) xfer_count <= xfer_count + 1'b1;
         if (in_xfer)  last_grant <= grant;
`ifdef CHAR_SELECT_SKID_EN
         // A held skid entry always drains before any new input reaches the output.
         if (slot_free) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_data   <= skid_data;
               out_ch     <= skid_ch;
               skid_valid <= 1'b0;
            end else if (in_xfer) begin
               out_valid <= 1'b1;
               out_data  <= sel_data;
               out_ch    <= grant;
            end else if (out_xfer) begin
               out_valid <= 1'b0;
            end
         end else if (in_xfer) begin
            skid_valid <= 1'b1;
            skid_data  <= sel_data;
            skid_ch    <= grant;
         end
`else
         if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant;
         end else if (out_xfer) begin
            out_valid <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_char_select_arb.sv
// Self-checking bench for char_select_arb: directed scenarios plus random
// traffic against a queue-based reference model (honours CHAR_SELECT_SKID_EN).
module tb_char_select_arb;
   import char_sel_pkg::*;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          rr_mode;
   logic [3:0]    in_valid;
   logic [31:0]   in_data;
   logic [3:0]    in_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic [1:0]    out_ch;
   logic          out_ready;
   logic [CW-1:0] xfer_count;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] d;
      int         ch;
   } ent_t;

   // Characters accepted but not yet delivered downstream, oldest first.
   ent_t       q[$];
   int         m_last  = NCH - 1;
   int         m_count = 0;
   int         m_ch    = 0;
   logic [7:0] m_data  = '0;

   char_select_arb #(
      .NCH (NCH),
      .DW  (DW),
      .CW  (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rr_mode    (rr_mode),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ch     (out_ch),
      .out_ready  (out_ready),
      .xfer_count (xfer_count)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic rr, input logic [3:0] v);
      for (int k = 0; k < NCH; k++) begin
         int j;
         j = rr ? (m_last + 1 + k) % NCH : k;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check against model, clock, advance model.
   task automatic cyc(input logic r, input logic rr, input logic [3:0] v,
                      input logic [31:0] d, input logic ordy);
      int         g;
      logic       ok;
      logic [3:0] exp_rdy;
      ent_t       e;
      rst = r; rr_mode = rr; in_valid = v; in_data = d; out_ready = ordy;
      #1;
      g = pick(rr, v);
`ifdef CHAR_SELECT_SKID_EN
      ok = (q.size() < 2);
`else
      ok = (q.size() == 0) || ordy;
`endif
      exp_rdy = (!r && g >= 0 && ok) ? (4'b0001 << g) : 4'b0000;
      chk("in_ready",   {28'd0, in_ready},   {28'd0, exp_rdy});
      chk("out_valid",  {31'd0, out_valid},  {31'd0, (q.size() > 0)});
      chk("out_data",   {24'd0, out_data},   {24'd0, m_data});
      chk("out_ch",     {30'd0, out_ch},     m_ch);
      chk("xfer_count", {28'd0, xfer_count}, m_count);
      @(posedge clk);
      if (r) begin
         q.delete();
         m_count = 0; m_last = NCH - 1; m_data = '0; m_ch = 0;
      end else begin
         if (q.size() > 0 && ordy) begin
            void'(q.pop_front());
            m_count = (m_count + 1) % (1 << CW);
         end
         if (exp_rdy != 4'b0000) begin
            e.d  = d[g*8 +: 8];
            e.ch = g;
            q.push_back(e);
            m_last = g;
         end
         if (q.size() > 0) begin
            m_data = q[0].d;
            m_ch   = q[0].ch;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] rr_exp [5];
      rr_exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
      rst = 1'b1; rr_mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
      @(negedge clk);

      // Reset, with requests present to show in_ready stays low.
      cyc(1, 0, 4'hF, 32'h44434241, 1);
      cyc(1, 1, 4'hF, 32'h44434241, 1);
      cyc(0, 0, 4'h0, 32'h0, 0);
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_count", {28'd0, xfer_count}, 32'd0);

      // Fixed priority: ch1 starves ch3 until ch1 drops.
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 4'b1010, 32'h43004100, 1);
         chk("fixed_data", {24'd0, out_data}, 32'h41);
         chk("fixed_ch",   {30'd0, out_ch},   32'd1);
      end
      cyc(0, 0, 4'b1000, 32'h43004100, 1);
      chk("fixed_ch3", {24'd0, out_data}, 32'h43);

      // Round-robin from a fresh reset.
      cyc(1, 1, 4'h0, 32'h0, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 4'hF, 32'h44434241, 1);
         chk("rr_seq", {24'd0, out_data}, {24'd0, rr_exp[i]});
      end
      cyc(0, 1, 4'h0, 32'h0, 1);
      chk("rr_count", {28'd0, xfer_count}, 32'd5);

      // Stall with 0x5A held while 0x5B keeps requesting.
      cyc(1, 0, 4'h0, 32'h0, 1);
      cyc(0, 0, 4'h1, 32'h5A, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 4'h1, 32'h5B, 0);
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_data",  {24'd0, out_data},  32'h5A);
      end
      cyc(0, 0, 4'h0, 32'h0, 1);
      chk("release_count", {28'd0, xfer_count}, 32'd1);
`ifdef CHAR_SELECT_SKID_EN
      chk("skid_data", {24'd0, out_data}, 32'h5B);
      cyc(0, 0, 4'h0, 32'h0, 1);
      chk("skid_count", {28'd0, xfer_count}, 32'd2);
`endif
      chk("release_empty", {31'd0, out_valid}, 32'd0);

      // Random traffic, including mode flips and occasional resets.
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 39) == 0, 1'($urandom), 4'($urandom),
             $urandom, $urandom_range(0, 3) != 0);
      end

      // Reset while a character is held.
      cyc(0, 1, 4'hF, 32'h64636261, 0);
      cyc(0, 1, 4'hF, 32'h64636261, 0);
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      cyc(1, 1, 4'hF, 32'h64636261, 0);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst_count", {28'd0, xfer_count}, 32'd0);
      cyc(0, 1, 4'hF, 32'h64636261, 1);
      chk("post_rst_ch", {30'd0, out_ch}, 32'd0);
      cyc(0, 1, 4'h0, 32'h0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
